queue_enq_arbiter: RTL

- Round-robin arbiter that shares the single enqueue port of a queue between NUM_REQ producers.
- Sits directly in front of the queue: out_valid/out_data drive the queue's enq/din, and the queue's enq_ready drives out_ready.
- Supports bounded bursts: a granted requester keeps the port for up to MAX_BURST consecutive accepted beats, then priority rotates.
- Zero-latency combinational grant path; the only state is the priority and burst bookkeeping.

---
 rtl/queue_enq_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/queue_enq_arbiter.sv
// Round-robin arbiter sharing one queue enqueue port among NUM_REQ producers,
// with bounded bursts and a zero-latency combinational grant path.
module queue_enq_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    input  logic                          out_ready
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic [ID_W-1:0]  eptr;
    logic [ID_W-1:0]  g;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic             owner_held;
    logic             any_valid;
    logic             transfer;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Handshake: a beat moves when out_valid && out_ready; in_ready is the
    // one-hot grant qualified by out_ready in the same cycle.
    always_comb begin
        owner_held = (state == BURST) && in_valid[owner];
        eptr       = (state == BURST && !in_valid[owner]) ? wrap_inc(owner) : ptr;
        g          = '0;
        cand       = '0;
        found      = 1'b0;
        if (owner_held) begin
            g     = owner;
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((int'(eptr) + k) % NUM_REQ);
                if (!found && in_valid[cand]) begin
                    g     = cand;
                    found = 1'b1;
                end
            end
        end
        any_valid = rst && (|in_valid);
        transfer  = any_valid && out_ready;
        out_valid = any_valid;
        out_id    = any_valid ? g : '0;
        out_data  = any_valid ? in_data[int'(g)*DATA_WIDTH +: DATA_WIDTH] : '0;
        in_ready  = transfer ? (NUM_REQ'(1) << g) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
            ptr      <= '0;
        end else if (owner_held) begin
            // Owner still requesting: count beats, stall holds everything.
            if (transfer) begin
                if (beat_cnt + 1'b1 == CNT_W'(MAX_BURST)) begin
                    state <= IDLE;
                    ptr   <= wrap_inc(owner);
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end else if (!transfer) begin
            state <= IDLE;
            ptr   <= eptr;
        end else if (MAX_BURST == 1) begin
            state <= IDLE;
            ptr   <= wrap_inc(g);
        end else begin
            state    <= BURST;
            owner    <= g;
            beat_cnt <= CNT_W'(1);
        end
    end

endmodule
